ot_wrr_pkt_arbiter_rstn: RTL and testbench
==========================================

OT_WRR_PKT_ARBITER_RSTN -- requirements
Module: ot_wrr_pkt_arbiter_rstn

Interface
REQ-001 SHALL have parameter IN_CNT, default 4, meaning the number of requesters (legal range 2..8).
REQ-002 SHALL have parameter WEIGHT_W, default 4, meaning the width of each per-requester weight field.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  meaning reset, asynchronous assert and active-low.
REQ-005 SHALL have port cfg_weight  input  [IN_CNT-1:0][WEIGHT_W-1:0]  meaning packets per turn for each requester.
REQ-006 SHALL have port req  input  IN_CNT  meaning per-requester valid.
REQ-007 SHALL have port req_last  input  IN_CNT  meaning the offered beat is the last beat of its packet.
REQ-008 SHALL have port ready  input  1  meaning the downstream accepts the granted beat this cycle.
REQ-009 SHALL have port grt  output  IN_CNT  meaning one-hot-or-zero grant, combinational from state and req.
REQ-010 SHALL have port grt_idx  output  $clog2(IN_CNT)  meaning the index of the grant bit; 0 when grt==0.
REQ-011 SHALL have port out_vld  output  1  meaning |grt.
REQ-012 SHALL have port locked  output  1  meaning a packet is in progress.

Function
REQ-013 SHALL keep state: ptr (index), cnt (WEIGHT_W bits), lock flag, and owner (index).
REQ-014 SHALL compute eff_weight(i) as cfg_weight[i], with 0 treated as 1.
REQ-015 SHALL grant, when unlocked, req[ptr] if set; otherwise the first set req circularly after ptr; otherwise grt=0.
REQ-016 SHALL grant, when locked, onehot(owner) if req[owner] is set, else 0; no other requester is granted while locked.
REQ-017 SHALL count a beat as accepted when grt[w] & ready; with ready low, no state changes.
REQ-018 SHALL set lock=1 and owner=w when an accepted beat has req_last[w]==0.
REQ-019 SHALL clear lock when an accepted beat has req_last[w]==1.
REQ-020 SHALL, on an accepted last beat by winner w, compute base = cnt if (w==ptr && cnt!=0), else eff_weight(w), and set rem = base-1.
REQ-021 SHALL, if rem==0, set ptr=(w+1) mod IN_CNT and cnt=0; otherwise set ptr=w and cnt=rem.
REQ-022 SHALL treat a single-beat packet (req_last=1 on the first beat) as one packet with no lock cycle.
REQ-023 SHALL apply cfg_weight changes only at the next base computation; an in-progress cnt is unaffected.
REQ-024 SHALL NOT change grt while locked and ready is low if req[owner] stays high; requesters hold data under the valid/ready rule.
REQ-025 SHALL have zero latency from req to grt; ptr, cnt and lock update one cycle after acceptance.
REQ-026 SHALL wrap ptr from IN_CNT-1 to 0.

Reset
REQ-027 SHALL, with rstn low, immediately force ptr=0, cnt=0, lock=0, owner=0, and therefore locked=0.
REQ-028 SHALL give grt, grt_idx and out_vld no reset value of their own; they follow REQ-015 from reset state, so requesters must hold req low during reset for grt=0.
REQ-029 SHALL abandon any in-progress packet lock when reset is asserted mid-packet, without recovery.

Structure
REQ-030 SHALL place shared constants (OT_ARB_MAX_IN=8, default WEIGHT_W) and the function eff_weight in package ot_arb_pkg.
REQ-031 SHALL implement the circular first-set search from ptr in a combinational sub-module ot_ffs_from_ptr (parameter IN_CNT; inputs vec, ptr; outputs found, idx).
REQ-032 SHALL be drop-in as the arbiter of the buffered N-input mux: grt drives the buffer ready signals, and out_vld drives the output pipeline valid.

Verification
REQ-033 SHALL cover weights: IN_CNT=4, weights {3,1,2,1}, all req high, single-beat packets, ready=1 -> grant order 0,0,0,1,2,2,3,0,...
REQ-034 SHALL cover packet lock: req0 sends a 4-beat packet and req1 is high throughout -> grt=0001 for all 4 beats; grt=0010 on the cycle after the last beat when weight0=1.
REQ-035 SHALL cover backpressure: locked on owner 2 with ready=0 for 5 cycles -> grt=0100 constant, and ptr, cnt and lock unchanged.
REQ-036 SHALL cover skip and wrap: ptr=3, only req1 high, weight1=2 -> grant 1; after its last beat, ptr=1 and cnt=1; the next packet from 1 sets ptr=2.
REQ-037 SHALL cover zero weight and reset: weight=0 on all, all req high -> plain round-robin 0,1,2,3; rstn pulsed low mid-packet -> locked=0 immediately and the next grant goes to requester 0.

Source files
------------

// File: rtl/ot_arb_pkg.sv
// Purpose: shared constants and helpers for the weighted round-robin packet arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ot_arb_pkg;

  localparam int OT_ARB_MAX_IN     = 8;
  localparam int OT_ARB_WEIGHT_W   = 4;
  // Widest weight field eff_weight can carry; callers zero-extend into it.
  localparam int OT_ARB_WEIGHT_MAX_W = 16;

  // A configured weight of 0 would starve a requester forever; treat it as 1.
  function automatic logic [OT_ARB_WEIGHT_MAX_W-1:0] eff_weight(
    input logic [OT_ARB_WEIGHT_MAX_W-1:0] w
  );
    return (w == '0) ? OT_ARB_WEIGHT_MAX_W'(1) : w;
  endfunction

endpackage

// File: rtl/ot_ffs_from_ptr.sv
// Purpose: circular find-first-set over vec, starting at (and including) ptr.
// Latency: purely combinational.
// Backpressure: none; evaluates every cycle.
// Ports: vec = request vector, ptr = search start index,
//        found = any bit set, idx = first set index at or after ptr (0 when none).
module ot_ffs_from_ptr #(
  parameter int IN_CNT = 4,
  localparam int IW    = (IN_CNT > 1) ? $clog2(IN_CNT) : 1
) (
  input  logic [IN_CNT-1:0] vec,
  input  logic [IW-1:0]     ptr,
  output logic              found,
  output logic [IW-1:0]     idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = IN_CNT - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % IN_CNT;
      if (vec[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ot_wrr_pkt_arbiter_rstn.sv
// Purpose: weighted round-robin arbiter that grants whole packets (locks on the owner until its last beat).
// Latency: req->grt zero cycles; ptr/cnt/lock update on the edge after an accepted beat.
// Backpressure: with ready low nothing changes, so grt holds while req stays asserted.
// Ports: clk/rstn (async active-low), cfg_weight = packets per turn per requester,
//        req/req_last = per-requester valid and last-beat flag, ready = downstream accept,
//        grt/grt_idx/out_vld = grant one-hot, its index, and |grt; locked = packet in progress.
module ot_wrr_pkt_arbiter_rstn
  import ot_arb_pkg::*;
#(
  parameter int IN_CNT   = 4,
  parameter int WEIGHT_W = OT_ARB_WEIGHT_W,
  localparam int IW      = (IN_CNT > 1) ? $clog2(IN_CNT) : 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [IN_CNT-1:0][WEIGHT_W-1:0]  cfg_weight,
  input  logic [IN_CNT-1:0]                req,
  input  logic [IN_CNT-1:0]                req_last,
  input  logic                             ready,
  output logic [IN_CNT-1:0]                grt,
  output logic [IW-1:0]                    grt_idx,
  output logic                             out_vld,
  output logic                             locked
);

  logic [IW-1:0]       ptr;
  logic [IW-1:0]       owner;
  logic [WEIGHT_W-1:0] cnt;
  logic                lock;

  logic                ffs_found;
  logic [IW-1:0]       ffs_idx;

  logic [OT_ARB_WEIGHT_MAX_W-1:0] w_ext;
  logic [OT_ARB_WEIGHT_MAX_W-1:0] base_ext;
  logic [OT_ARB_WEIGHT_MAX_W-1:0] rem_ext;
  logic [IW-1:0]                  next_ptr;

  ot_ffs_from_ptr #(.IN_CNT(IN_CNT)) u_ffs (
    .vec   (req),
    .ptr   (ptr),
    .found (ffs_found),
    .idx   (ffs_idx)
  );

  // While locked only the owner may be granted; otherwise search from ptr.
  always_comb begin
    grt     = '0;
    grt_idx = '0;
    if (lock) begin
      if (req[owner]) begin
        grt[owner] = 1'b1;
        grt_idx    = owner;
      end
    end else if (ffs_found) begin
      grt[ffs_idx] = 1'b1;
      grt_idx      = ffs_idx;
    end
  end

  assign out_vld = |grt;
  assign locked  = lock;

  // Remaining turn: continue the current turn's count only if the winner is
  // the turn holder with packets left; otherwise start a fresh turn, which is
  // where new cfg_weight values take effect.
  always_comb begin
    w_ext = OT_ARB_WEIGHT_MAX_W'(cfg_weight[grt_idx]);
    if ((grt_idx == ptr) && (cnt != '0)) begin
      base_ext = OT_ARB_WEIGHT_MAX_W'(cnt);
    end else begin
      base_ext = eff_weight(w_ext);
    end
    rem_ext  = base_ext - OT_ARB_WEIGHT_MAX_W'(1);
    next_ptr = (grt_idx == IW'(IN_CNT - 1)) ? '0 : grt_idx + IW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr   <= '0;
      cnt   <= '0;
      lock  <= 1'b0;
      owner <= '0;
    end else if (out_vld && ready) begin
      if (!req_last[grt_idx]) begin
        lock  <= 1'b1;
        owner <= grt_idx;
      end else begin
        lock <= 1'b0;
        if (rem_ext == '0) begin
          ptr <= next_ptr;
          cnt <= '0;
        end else begin
          ptr <= grt_idx;
          cnt <= rem_ext[WEIGHT_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_ot_wrr_pkt_arbiter_rstn.sv
module tb_ot_wrr_pkt_arbiter_rstn;

  logic             clk;
  logic             rstn;
  logic [3:0][3:0]  cfg_weight;
  logic [3:0]       req;
  logic [3:0]       req_last;
  logic             ready;
  logic [3:0]       grt;
  logic [1:0]       grt_idx;
  logic             out_vld;
  logic             locked;

  int vectors;
  int miscompares;

  ot_wrr_pkt_arbiter_rstn #(.IN_CNT(4), .WEIGHT_W(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfg_weight (cfg_weight),
    .req        (req),
    .req_last   (req_last),
    .ready      (ready),
    .grt        (grt),
    .grt_idx    (grt_idx),
    .out_vld    (out_vld),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle just past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req      = 4'b0000;
    req_last = 4'b0000;
    ready    = 1'b0;
    rstn     = 1'b0;
    cyc();
    cyc();
    rstn = 1'b1;
    #1;
  endtask

  int exp_seq[8] = '{0, 0, 0, 1, 2, 2, 3, 0};

  initial begin
    vectors     = 0;
    miscompares = 0;
    cfg_weight  = 16'h1111;
    do_reset();

    // Reset state with req low.
    chk("rst_grt",     32'(grt),       32'h0);
    chk("rst_grt_idx", 32'(grt_idx),   32'h0);
    chk("rst_out_vld", 32'(out_vld),   32'h0);
    chk("rst_locked",  32'(locked),    32'h0);
    chk("rst_ptr",     32'(dut.ptr),   32'h0);
    chk("rst_cnt",     32'(dut.cnt),   32'h0);

    // Weighted order: weights {3,1,2,1}, all single-beat packets.
    cfg_weight = 16'h1213;
    req        = 4'b1111;
    req_last   = 4'b1111;
    ready      = 1'b1;
    for (int n = 0; n < 8; n++) begin
      #1;
      chk($sformatf("wrr_grt_%0d", n), 32'(grt),     32'(1 << exp_seq[n]));
      chk($sformatf("wrr_idx_%0d", n), 32'(grt_idx), 32'(exp_seq[n]));
      cyc();
    end

    // Packet lock: req0 sends 4 beats while req1 keeps requesting.
    do_reset();
    cfg_weight = 16'h1111;
    req        = 4'b0011;
    ready      = 1'b1;
    for (int b = 0; b < 4; b++) begin
      req_last = (b == 3) ? 4'b0011 : 4'b0010;
      #1;
      chk($sformatf("lock_grt_beat%0d", b), 32'(grt), 32'h1);
      cyc();
      if (b < 3) chk($sformatf("lock_locked_beat%0d", b), 32'(locked), 32'h1);
    end
    chk("lock_released", 32'(locked),  32'h0);
    chk("lock_next_grt", 32'(grt),     32'h2);
    chk("lock_ptr",      32'(dut.ptr), 32'h1);

    // Backpressure: lock on owner 2, then hold ready low for 5 cycles.
    do_reset();
    cfg_weight = 16'h1111;
    req        = 4'b0100;
    req_last   = 4'b0000;
    ready      = 1'b1;
    cyc();
    chk("bp_locked", 32'(locked), 32'h1);
    req   = 4'b1111;
    ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_grt_%0d", c), 32'(grt), 32'h4);
      cyc();
      chk($sformatf("bp_state_%0d", c),
          32'({locked, dut.ptr, dut.cnt}), 32'({1'b1, 2'd0, 4'd0}));
    end
    req_last = 4'b0100;
    ready    = 1'b1;
    #1;
    chk("bp_last_grt", 32'(grt), 32'h4);
    cyc();
    chk("bp_after_ptr",    32'(dut.ptr), 32'h3);
    chk("bp_after_locked", 32'(locked),  32'h0);

    // Skip and wrap: ptr=3, only req1 high, weight1=2, 2-beat packet.
    cfg_weight = 16'h1121;
    req        = 4'b0010;
    req_last   = 4'b0000;
    #1;
    chk("skip_grt", 32'(grt), 32'h2);
    cyc();
    req_last = 4'b0010;
    cyc();
    chk("skip_ptr_cnt", 32'({dut.ptr, dut.cnt}), 32'({2'd1, 4'd1}));
    // A weight change mid-turn must not disturb the remaining count.
    cfg_weight = 16'h1131;
    #1;
    chk("skip2_grt", 32'(grt), 32'h2);
    cyc();
    chk("skip2_ptr_cnt", 32'({dut.ptr, dut.cnt}), 32'({2'd2, 4'd0}));

    // Zero weights behave as 1: plain round-robin.
    do_reset();
    cfg_weight = 16'h0000;
    req        = 4'b1111;
    req_last   = 4'b1111;
    ready      = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk($sformatf("zw_idx_%0d", n), 32'(grt_idx), 32'(n));
      cyc();
    end
    // Single beat from 0, then start a multi-beat packet from 1.
    cyc();
    req_last = 4'b0000;
    #1;
    chk("rst_mid_grt", 32'(grt), 32'h2);
    cyc();
    chk("rst_mid_locked", 32'(locked), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_async_locked", 32'(locked),  32'h0);
    chk("rst_async_ptr",    32'(dut.ptr), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_after_grt", 32'(grt), 32'h1);
    cyc();
    chk("rst_after_locked", 32'(locked), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
